// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use stall, taken-branch flush and mult/div occupancy control
//   clk, rst_n                 pipeline clock, async active-low reset
//   Id_Rs, Id_Rt, Id_UsesRt    source operands of the instruction in ID
//   Ex_MemRead, Ex_Rw          EX instruction is a load / its destination
//   Ex_MulDiv, Ex_BranchTaken  EX instruction is mult/div / branch resolved taken
//   PC_Wr, IfId_Wr, IdEx_Wr    pipeline register write-enables (1 = advance)
//   IfId_Flush, IdEx_Flush, ExMem_Flush  load a bubble into that register
//   md_go, md_sel, md_busy     mult/div start pulse, result select, occupancy
//   stall_cnt                  saturating count of cycles with PC_Wr=0
module pipe_hazard_ctrl #(
    parameter int MD_LAT = 32,
    parameter int CNT_W  = $clog2(MD_LAT)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  Id_Rs,
    input  logic [4:0]  Id_Rt,
    input  logic        Id_UsesRt,
    input  logic        Ex_MemRead,
    input  logic [4:0]  Ex_Rw,
    input  logic        Ex_MulDiv,
    input  logic        Ex_BranchTaken,
    output logic        PC_Wr,
    output logic        IfId_Wr,
    output logic        IdEx_Wr,
    output logic        IfId_Flush,
    output logic        IdEx_Flush,
    output logic        ExMem_Flush,
    output logic        md_go,
    output logic        md_sel,
    output logic        md_busy,
    output logic [15:0] stall_cnt
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic load_use, hold, br, lu;

    assign load_use = Ex_MemRead && Ex_Rw != 5'd0 &&
                      (Ex_Rw == Id_Rs || (Id_UsesRt && Ex_Rw == Id_Rt));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            stall_cnt <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (!PC_Wr && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
        end
    end

    // The first mult/div cycle is spent in IDLE, so BUSY lasts MD_LAT-2 cycles before DONE.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: if (Ex_MulDiv) begin
                state_nx = MD_LAT > 2 ? BUSY : DONE;
                cnt_nx   = MD_LAT > 2 ? CNT_W'(MD_LAT - 2) : '0;
            end
            BUSY: begin
                cnt_nx   = cnt - 1'b1;
                state_nx = cnt == CNT_W'(1) ? DONE : BUSY;
            end
            default: state_nx = IDLE;
        endcase
    end

    // While EX is occupied by mult/div every other hazard is masked; branch beats load-use.
    always_comb begin
        hold        = (state == IDLE && Ex_MulDiv) || state == BUSY;
        br          = !hold && Ex_BranchTaken;
        lu          = !hold && !Ex_BranchTaken && load_use;
        PC_Wr       = !hold && !lu;
        IfId_Wr     = !hold && !lu;
        IdEx_Wr     = !hold;
        IfId_Flush  = br;
        IdEx_Flush  = br || lu;
        ExMem_Flush = hold;
        md_go       = state == IDLE && Ex_MulDiv;
        md_sel      = state == DONE;
        md_busy     = state != IDLE;
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed checks of stalls, flushes, mult/div sequencing and stall counting
module tb_pipe_hazard_ctrl;
    logic clk = 1'b0, rst_n = 1'b0;
    logic [4:0] Id_Rs = '0, Id_Rt = '0, Ex_Rw = '0;
    logic Id_UsesRt = 1'b0, Ex_MemRead = 1'b0, Ex_MulDiv = 1'b0, Ex_BranchTaken = 1'b0;
    logic a_pc, a_ifid, a_idex, a_fif, a_fidex, a_fexm, a_go, a_sel, a_busy;
    logic b_pc, b_ifid, b_idex, b_fif, b_fidex, b_fexm, b_go, b_sel, b_busy;
    logic [15:0] a_stall, b_stall;
    logic [8:0] a_ctl, b_ctl;
    logic seen_sel;
    int errs = 0, checks = 0;

    always #5 clk = ~clk;

    // ctl vectors: {PC_Wr,IfId_Wr,IdEx_Wr, IfId_Flush,IdEx_Flush,ExMem_Flush, md_go,md_sel,md_busy}
    assign a_ctl = {a_pc, a_ifid, a_idex, a_fif, a_fidex, a_fexm, a_go, a_sel, a_busy};
    assign b_ctl = {b_pc, b_ifid, b_idex, b_fif, b_fidex, b_fexm, b_go, b_sel, b_busy};

    pipe_hazard_ctrl #(.MD_LAT(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .Id_Rs(Id_Rs), .Id_Rt(Id_Rt), .Id_UsesRt(Id_UsesRt),
        .Ex_MemRead(Ex_MemRead), .Ex_Rw(Ex_Rw), .Ex_MulDiv(Ex_MulDiv),
        .Ex_BranchTaken(Ex_BranchTaken), .PC_Wr(a_pc), .IfId_Wr(a_ifid), .IdEx_Wr(a_idex),
        .IfId_Flush(a_fif), .IdEx_Flush(a_fidex), .ExMem_Flush(a_fexm), .md_go(a_go),
        .md_sel(a_sel), .md_busy(a_busy), .stall_cnt(a_stall));

    pipe_hazard_ctrl #(.MD_LAT(32)) dut_b (
        .clk(clk), .rst_n(rst_n), .Id_Rs(Id_Rs), .Id_Rt(Id_Rt), .Id_UsesRt(Id_UsesRt),
        .Ex_MemRead(Ex_MemRead), .Ex_Rw(Ex_Rw), .Ex_MulDiv(Ex_MulDiv),
        .Ex_BranchTaken(Ex_BranchTaken), .PC_Wr(b_pc), .IfId_Wr(b_ifid), .IdEx_Wr(b_idex),
        .IfId_Flush(b_fif), .IdEx_Flush(b_fidex), .ExMem_Flush(b_fexm), .md_go(b_go),
        .md_sel(b_sel), .md_busy(b_busy), .stall_cnt(b_stall));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #3;
        chk("reset_ctl", a_ctl, 9'b111_000_000);
        chk("reset_stall", a_stall, 0);
        #4 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("idle_ctl", a_ctl, 9'b111_000_000);
        end
        chk("idle_stall", a_stall, 0);
        // load-use on Rs
        Ex_MemRead = 1'b1; Ex_Rw = 5'd8; Id_Rs = 5'd8;
        #1 chk("lu_rs_ctl", a_ctl, 9'b001_010_000);
        cyc();
        Ex_MemRead = 1'b0; Ex_Rw = 5'd0; Id_Rs = 5'd0;
        #1 chk("lu_after_ctl", a_ctl, 9'b111_000_000);
        chk("lu_stall", a_stall, 1);
        // Ex_Rw = 0 never stalls
        Ex_MemRead = 1'b1;
        #1 chk("r0_ctl", a_ctl, 9'b111_000_000);
        cyc();
        chk("r0_stall", a_stall, 1);
        // load-use on Rt, only when Rt is read
        Ex_Rw = 5'd5; Id_Rt = 5'd5; Id_Rs = 5'd3; Id_UsesRt = 1'b1;
        #1 chk("lu_rt_ctl", a_ctl, 9'b001_010_000);
        cyc();
        Id_UsesRt = 1'b0;
        #1 chk("rt_unused_ctl", a_ctl, 9'b111_000_000);
        cyc();
        chk("lu_rt_stall", a_stall, 2);
        Ex_MemRead = 1'b0; Ex_Rw = 5'd0; Id_Rt = 5'd0; Id_Rs = 5'd0;
        // mult/div with MD_LAT=4, illegal branch at T0 is ignored
        Ex_MulDiv = 1'b1; Ex_BranchTaken = 1'b1;
        #1 chk("md_t0", a_ctl, 9'b000_001_100);
        cyc();
        Ex_BranchTaken = 1'b0;
        #1 chk("md_t1", a_ctl, 9'b000_001_001);
        cyc();
        chk("md_t2", a_ctl, 9'b000_001_001);
        cyc();
        Ex_BranchTaken = 1'b1;
        #1 chk("md_t3_done_br", a_ctl, 9'b111_110_011);
        Ex_BranchTaken = 1'b0;
        #1 chk("md_t3_done", a_ctl, 9'b111_000_011);
        Ex_MulDiv = 1'b0;
        cyc();
        chk("md_t4", a_ctl, 9'b111_000_000);
        chk("md_stall", a_stall, 5);
        // branch beats load-use
        Ex_MemRead = 1'b1; Ex_Rw = 5'd8; Id_Rs = 5'd8; Ex_BranchTaken = 1'b1;
        #1 chk("br_lu_ctl", a_ctl, 9'b111_110_000);
        cyc();
        Ex_MemRead = 1'b0; Ex_Rw = 5'd0; Id_Rs = 5'd0; Ex_BranchTaken = 1'b0;
        #1 chk("br_stall", a_stall, 5);
        // reset mid-op on MD_LAT=32 instance
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        Ex_MulDiv = 1'b1;
        cyc();
        cyc();
        Ex_MulDiv = 1'b0;
        cyc();
        chk("b_busy_t2", b_busy, 1);
        rst_n = 1'b0;
        #1 chk("b_rst_busy", b_busy, 0);
        chk("b_rst_stall", b_stall, 0);
        chk("b_rst_ctl", b_ctl, 9'b111_000_000);
        #1 rst_n = 1'b1;
        seen_sel = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (b_sel || b_go) seen_sel = 1'b1;
        end
        chk("b_no_sel", seen_sel, 0);
        chk("b_post_stall", b_stall, 0);
        // saturation via back-to-back mult/div
        Ex_MulDiv = 1'b1;
        for (int i = 0; i < 70000 && b_stall != 16'hFFFF; i++) cyc();
        chk("sat_reach", b_stall, 16'hFFFF);
        for (int i = 0; i < 100; i++) cyc();
        chk("sat_hold", b_stall, 16'hFFFF);
        Ex_MulDiv = 1'b0;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline hazard controller for the 5-stage CPU: it generates the PC / IF/ID / ID/EX write-enables and bubble/flush controls that the forwarding path cannot resolve on its own. It covers load-use stalls, taken-branch flushes and the multi-cycle mult/div occupancy of the EX stage. It sits beside the forwarding detector, takes decoded register fields from ID/EX, and drives the pipeline registers plus the iterative mult/div unit start/select.

## Interface
- MD_LAT, 32: total cycles a mult/div instruction occupies EX (legal ≥2)
- CNT_W, $clog2(MD_LAT): occupancy counter width
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous, active-low reset
- Id_Rs, Id_Rt  in  5 each  source registers of the instruction in ID
- Id_UsesRt  in  1  ID instruction reads Rt as an operand
- Ex_MemRead  in  1  EX instruction is a load
- Ex_Rw  in  5  EX destination register
- Ex_MulDiv  in  1  EX instruction is mult/div
- Ex_BranchTaken  in  1  EX branch/jump resolved taken
- PC_Wr, IfId_Wr, IdEx_Wr  out  1 each  register write-enables (1 = advance)
- IfId_Flush, IdEx_Flush, ExMem_Flush  out  1 each  load a bubble (all controls 0)
- md_go  out  1  one-cycle start pulse to the mult/div unit
- md_sel  out  1  select mult/div result into EX/MEM
- md_busy  out  1  FSM not IDLE
- stall_cnt  out  16  saturating count of cycles with PC_Wr=0

## Operation
- States: IDLE, BUSY, DONE; cnt is CNT_W bits.
- load_use = Ex_MemRead && Ex_Rw≠0 && (Ex_Rw==Id_Rs || (Id_UsesRt && Ex_Rw==Id_Rt)).
- IDLE, Ex_MulDiv=1:
  - md_go=1; PC_Wr=IfId_Wr=IdEx_Wr=0; ExMem_Flush=1.
  - Next state BUSY with cnt=MD_LAT-2 if MD_LAT>2, else DONE.
  - Ex_BranchTaken and load_use are ignored.
- IDLE, Ex_MulDiv=0, Ex_BranchTaken=1: IfId_Flush=IdEx_Flush=1; all write-enables 1. Branch has priority over load_use.
- IDLE, load_use only: PC_Wr=IfId_Wr=0, IdEx_Flush=1, IdEx_Wr=1. Exactly one bubble per occurrence.
- BUSY:
  - Same holds as the IDLE mult/div cycle (PC_Wr=IfId_Wr=IdEx_Wr=0, ExMem_Flush=1), but md_go=0.
  - If cnt==1, next state is DONE; otherwise cnt decrements.
  - All other inputs are ignored.
- DONE:
  - md_sel=1; all write-enables 1; ExMem_Flush=0.
  - Mult/div result is captured in EX/MEM; next state IDLE.
  - Ex_BranchTaken and load_use are evaluated as in IDLE (branch priority). Ex_MulDiv is ignored.
- md_busy = (state≠IDLE).
- stall_cnt increments each cycle PC_Wr=0 and saturates at 16'hFFFF.
- Ex_MulDiv and Ex_BranchTaken both high is illegal; Ex_MulDiv wins.
- Ex_Rw==0 never causes a stall.

## Timing
- Reset values: state=IDLE, cnt=0, stall_cnt=0.
  - With inputs idle, outputs are PC_Wr=IfId_Wr=IdEx_Wr=1, all flushes 0, md_go=md_sel=md_busy=0.
- rst_n low at any time, including mid-BUSY: state, cnt and stall_cnt clear asynchronously, with no further md_go.
- Control outputs are combinational from state plus the current-cycle inputs. Zero latency: a hazard visible in cycle T is acted on at the clock edge ending T.
- Mult/div in EX at T0 occupies EX for T0..T0+MD_LAT-1.
  - md_go at T0 only; md_sel at T0+MD_LAT-1 only.
  - The front end stalls MD_LAT-1 cycles.
- Load-use: 1 stall cycle; the load reaches MEM while the dependent instruction is held in ID, then forwarding resolves it.
- Taken branch: 2 wrong-path instructions (in IF/ID and ID/EX) are squashed in the same cycle.
- stall_cnt updates on the clock edge; it lags PC_Wr by one cycle.

## Test plan
- Reset release, no hazards for 10 cycles -> all write-enables 1, flushes 0, stall_cnt=0, md_busy=0.
- Ex_MemRead=1, Ex_Rw=8, Id_Rs=8 for 1 cycle -> PC_Wr=IfId_Wr=0, IdEx_Flush=1 that cycle, normal next cycle, stall_cnt=1. Repeat with Ex_Rw=0 -> no stall.
- MD_LAT=4, Ex_MulDiv=1 held -> md_go at T0, holds T0–T2, md_sel at T3, IDLE at T4, stall_cnt=3.
- Ex_BranchTaken=1 with load_use true -> IfId_Flush=IdEx_Flush=1, PC_Wr=1, no stall counted.
- rst_n pulsed low at T2 of MD_LAT=32 op -> md_busy=0 immediately, no md_sel ever, stall_cnt=0.
- Force 65540 stall cycles (repeated mult/div) -> stall_cnt holds at 16'hFFFF.
